// File: rtl/sysu_spi_slave.sv
// sysu_spi_slave: mode-0 SPI slave with oversampled inputs and a 2-bit cs/rd/wr CPU register port.
module sysu_spi_slave #(
    parameter int         SYNC_STAGES  = 2,
    parameter int         IDLE_TIMEOUT = 255,
    parameter logic [7:0] TX_FILL      = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] addr,
    input  logic [7:0] in_data,
    output logic [7:0] out_data,
    input  logic       rd,
    input  logic       wr,
    input  logic       cs,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss_n,
    output logic       miso,
    output logic       miso_oe,
    output logic       irq
);
    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic       sclk_prev_q;
    logic [7:0] shift_rx_q, shift_rx_d, shift_tx_q, shift_tx_d;
    logic [7:0] rx_data_q, rx_data_d, tx_hold_q, tx_hold_d;
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       rx_valid_q, rx_valid_d, overrun_q, overrun_d;
    logic       tx_empty_q, tx_empty_d, tx_fresh_q, tx_fresh_d, miso_q;
    logic       sclk_s, mosi_s, sel, edge_any, rise, fall, done, abort;
    logic       pop, wr0, ovr_clr, pend, reload;
    logic [7:0] hold_v, rx_byte;

    always_comb begin
        sclk_s   = sclk_sync_q[SYNC_STAGES-1];
        mosi_s   = mosi_sync_q[SYNC_STAGES-1];
        sel      = ~ss_sync_q[SYNC_STAGES-1];
        edge_any = sclk_s ^ sclk_prev_q;
        rise     = sel & sclk_s & ~sclk_prev_q;
        fall     = sel & ~sclk_s & sclk_prev_q & (bitcnt_q != 3'd0);
        abort    = idle_cnt_q == 8'(IDLE_TIMEOUT);
        done     = rise & (bitcnt_q == 3'd7) & ~abort;
        pop      = cs & rd & (addr == 2'd0);
        wr0      = cs & wr & (addr == 2'd0);
        ovr_clr  = cs & wr & (addr == 2'd1) & in_data[2];
        pend     = wr0 | ~tx_empty_q;
        hold_v   = wr0 ? in_data : tx_hold_q;
        // While deselected a freshly loaded hold byte is kept; anything else is refreshed.
        reload   = sel ? (done | abort) : (pend | ~tx_fresh_q);
        rx_byte  = {shift_rx_q[6:0], mosi_s};
        tx_hold_d  = hold_v;
        tx_empty_d = (reload & pend) ? 1'b1 : (wr0 ? 1'b0 : tx_empty_q);
        tx_fresh_d = reload ? pend : (fall ? 1'b0 : tx_fresh_q);
        shift_tx_d = reload ? (pend ? hold_v : TX_FILL) : (fall ? {shift_tx_q[6:0], 1'b0} : shift_tx_q);
        bitcnt_d   = (~sel | abort | done) ? 3'd0 : (rise ? bitcnt_q + 3'd1 : bitcnt_q);
        shift_rx_d = abort ? 8'h00 : (rise ? rx_byte : shift_rx_q);
        rx_data_d  = done ? rx_byte : rx_data_q;
        rx_valid_d = done | (rx_valid_q & ~pop);
        overrun_d  = (done & rx_valid_q & ~pop) | (overrun_q & ~ovr_clr);
        idle_cnt_d = (~sel | (bitcnt_q == 3'd0) | edge_any | abort) ? 8'd0 : idle_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            shift_rx_q  <= 8'h00;
            shift_tx_q  <= TX_FILL;
            rx_data_q   <= 8'h00;
            tx_hold_q   <= 8'h00;
            idle_cnt_q  <= 8'd0;
            bitcnt_q    <= 3'd0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            tx_empty_q  <= 1'b1;
            tx_fresh_q  <= 1'b0;
            miso_q      <= TX_FILL[7];
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
            sclk_prev_q <= sclk_s;
            shift_rx_q  <= shift_rx_d;
            shift_tx_q  <= shift_tx_d;
            rx_data_q   <= rx_data_d;
            tx_hold_q   <= tx_hold_d;
            idle_cnt_q  <= idle_cnt_d;
            bitcnt_q    <= bitcnt_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            tx_empty_q  <= tx_empty_d;
            tx_fresh_q  <= tx_fresh_d;
            miso_q      <= shift_tx_q[7];
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = ~ss_sync_q[SYNC_STAGES-1];
    assign irq      = rx_valid_q | overrun_q;
    assign out_data = ~(cs & rd) ? 8'h00 :
                      (addr == 2'd0) ? rx_data_q :
                      (addr == 2'd1) ? {5'b0, overrun_q, tx_empty_q, rx_valid_q} :
                      (addr == 2'd2) ? {5'b0, bitcnt_q} : 8'h00;
endmodule

// File: tb/tb_sysu_spi_slave.sv
// tb_sysu_spi_slave: directed scoreboard bench driving a mode-0 master against sysu_spi_slave.
module tb_sysu_spi_slave;
    localparam int HALF = 8;
    logic       clk = 1'b0;
    logic       rst_n, rd, wr, cs, sclk, mosi, ss_n, miso, miso_oe, irq;
    logic [1:0] addr;
    logic [7:0] in_data, out_data, v, mb, dummy;
    logic [7:0] exp_miso[$];
    logic [7:0] exp_rx[$];
    int checks = 0;
    int errors = 0;

    sysu_spi_slave #(.SYNC_STAGES(2), .IDLE_TIMEOUT(16), .TX_FILL(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .in_data(in_data), .out_data(out_data),
        .rd(rd), .wr(wr), .cs(cs), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
        .miso(miso), .miso_oe(miso_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1 d = out_data;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; in_data = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] b, input int nbits, input bit pop_last,
                        input logic [7:0] pexp, output logic [7:0] m);
        m = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            m = {m[6:0], miso};
            if (pop_last && i == nbits - 1) begin
                repeat (2) @(negedge clk);
                cs = 1'b1; rd = 1'b1; addr = 2'd0;
                #1 chk("pop_collide_read", out_data, pexp);
                @(negedge clk);
                cs = 1'b0; rd = 1'b0;
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sclk = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 2'd0; in_data = 8'h00;
        sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_miso", {7'b0, miso}, 8'h01);
        chk("rst_miso_oe", {7'b0, miso_oe}, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("idle_out_data", out_data, 8'h00);
        rd_reg(2'd1, v); chk("rst_status", v, 8'h02);
        rd_reg(2'd2, v); chk("rst_bitcnt", v, 8'h00);
        rd_reg(2'd0, v); chk("rst_rx_data", v, 8'h00);
        rd_reg(2'd3, v); chk("rst_addr3", v, 8'h00);

        wr_reg(2'd0, 8'h3C);
        repeat (3) @(negedge clk);
        ss_n = 1'b0;
        repeat (6) @(negedge clk);
        chk("sel_miso_oe", {7'b0, miso_oe}, 8'h01);
        exp_miso.push_back(8'h3C); exp_rx.push_back(8'hA5);
        xfer(8'hA5, 8, 1'b0, 8'h00, mb);
        chk("basic_miso", mb, exp_miso.pop_front());
        repeat (4) @(negedge clk);
        chk("basic_irq", {7'b0, irq}, 8'h01);
        rd_reg(2'd1, v); chk("basic_status", v, 8'h03);
        rd_reg(2'd0, v); chk("basic_rx", v, exp_rx.pop_front());
        #1 chk("basic_irq_after_pop", {7'b0, irq}, 8'h00);

        exp_miso.push_back(8'hFF); exp_rx.push_back(8'h01);
        xfer(8'h01, 8, 1'b0, 8'h00, mb);
        chk("fill_miso", mb, exp_miso.pop_front());
        rd_reg(2'd1, v); chk("fill_status", v, 8'h03);
        rd_reg(2'd0, v); chk("fill_rx", v, exp_rx.pop_front());

        exp_rx.push_back(8'h22);
        xfer(8'h11, 8, 1'b0, 8'h00, mb);
        xfer(8'h22, 8, 1'b0, 8'h00, mb);
        rd_reg(2'd1, v); chk("ovr_status", v, 8'h07);
        wr_reg(2'd1, 8'h04);
        rd_reg(2'd1, v); chk("ovr_cleared_status", v, 8'h03);
        #1 chk("ovr_irq_held", {7'b0, irq}, 8'h01);
        rd_reg(2'd0, v); chk("ovr_rx", v, exp_rx.pop_front());
        #1 chk("ovr_irq_after_pop", {7'b0, irq}, 8'h00);

        exp_rx.push_back(8'h5A); exp_rx.push_back(8'h96);
        xfer(8'h5A, 8, 1'b0, 8'h00, mb);
        xfer(8'h96, 8, 1'b1, exp_rx.pop_front(), mb);
        rd_reg(2'd1, v); chk("collide_status", v, 8'h03);
        rd_reg(2'd0, v); chk("collide_rx", v, exp_rx.pop_front());

        xfer(8'hE0, 3, 1'b0, 8'h00, dummy);
        rd_reg(2'd2, v); chk("abort_bitcnt_before", v, 8'h03);
        repeat (20) @(negedge clk);
        rd_reg(2'd2, v); chk("abort_bitcnt_after", v, 8'h00);
        rd_reg(2'd1, v); chk("abort_status", v, 8'h02);
        exp_miso.push_back(8'hFF); exp_rx.push_back(8'hC3);
        xfer(8'hC3, 8, 1'b0, 8'h00, mb);
        chk("abort_next_miso", mb, exp_miso.pop_front());
        rd_reg(2'd0, v); chk("abort_next_rx", v, exp_rx.pop_front());

        xfer(8'h5F, 5, 1'b0, 8'h00, dummy);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("midrst_miso", {7'b0, miso}, 8'h01);
        chk("midrst_irq", {7'b0, irq}, 8'h00);
        rd_reg(2'd2, v); chk("midrst_bitcnt", v, 8'h00);
        rd_reg(2'd1, v); chk("midrst_status", v, 8'h02);
        repeat (4) @(negedge clk);
        exp_miso.push_back(8'hFF); exp_rx.push_back(8'h77);
        xfer(8'h77, 8, 1'b0, 8'h00, mb);
        chk("midrst_next_miso", mb, exp_miso.pop_front());
        rd_reg(2'd0, v); chk("midrst_next_rx", v, exp_rx.pop_front());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sysu_spi_slave.md
# sysu_spi_slave

SPI slave endpoint that sits directly downstream of the team's SPI master on the serial side and presents received bytes to a local CPU through the same 2-bit-address `cs`/`rd`/`wr` register bus as the master. The block oversamples `sclk`, `mosi` and `ss_n` with the system clock. It receives mode-0 (CPOL=0, CPHA=0), MSB-first bytes and returns a CPU-loaded transmit byte on `miso` in the same frame.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronizers; legal range 2–3.
- `IDLE_TIMEOUT`, 255: number of clk cycles with no `sclk` edge that aborts a partially received byte; legal range 1–255.
- `TX_FILL`, 8'hFF: byte shifted out when no transmit byte is pending.
- `clk` in 1: system clock. Rising edge only.
- `rst_n` in 1: reset; one clock; reset is synchronous and active-low.
- `addr` in 2: register select.
- `in_data` in 8: CPU write data.
- `out_data` out 8: CPU read data. Combinational; 8'h00 when not reading.
- `rd` in 1: read strobe, one clk wide, qualified by `cs`.
- `wr` in 1: write strobe, one clk wide, qualified by `cs`.
- `cs` in 1: block select.
- `sclk` in 1: serial clock from master; asynchronous to `clk`.
- `mosi` in 1: serial data in; asynchronous to `clk`.
- `ss_n` in 1: active-low slave select. Tie low for a master without slave select.
- `miso` out 1: serial data out.
- `miso_oe` out 1: output enable for an external tristate; equals synchronized `~ss_n`.
- `irq` out 1: level; equals `rx_valid | overrun`.

## Operation
- **Registers.**
  - addr 00, read: `rx_data`. A `cs&rd` cycle also pops: clears `rx_valid` at the next clk edge.
  - addr 00, write: loads `tx_hold` and clears `tx_empty`.
  - addr 01, read: {5'b0, `overrun`, `tx_empty`, `rx_valid`}.
  - addr 01, write: bit2=1 clears `overrun`; other bits ignored.
  - addr 10, read: {5'b0, `bitcnt`}.
  - addr 11: reads 8'h00; writes are ignored.
- **Synchronizers.** `sclk`, `mosi` and `ss_n` each pass through `SYNC_STAGES` flops. Edges of `sclk` are detected on the last two synchronized samples.
- **Frame.**
  - Synchronized `ss_n` high: holds `bitcnt`=0 and `idle_cnt`=0, and reloads `shift_tx`.
  - Reload source: `tx_hold` if `!tx_empty`, else `TX_FILL`. A reload from `tx_hold` sets `tx_empty`=1.
  - `miso` always equals `shift_tx[7]`.
- **Receive.** On a detected rising edge of `sclk` with `ss_n` low:
  - `shift_rx` <= {`shift_rx`[6:0], `mosi_sync`}; `bitcnt`++.
  - When `bitcnt` reaches 8: `rx_data` <= the completed byte; `rx_valid`<=1; `bitcnt`<=0.
  - In the same cycle `shift_tx` reloads, by the same rule as above, for the next byte.
  - If `rx_valid` was already 1 and no pop occurs in that cycle, set `overrun`=1. The newer byte overwrites `rx_data`.
- **Transmit.** On a detected falling edge of `sclk` with `bitcnt`≠0: `shift_tx` <= {`shift_tx`[6:0], 1'b0}.
- **Idle abort.**
  - `idle_cnt` counts clk cycles since the last `sclk` edge while `bitcnt`≠0.
  - When `idle_cnt` reaches `IDLE_TIMEOUT`: `bitcnt`<=0, `shift_rx` is discarded, and `shift_tx` reloads with its current source; `tx_empty` is unchanged unless that source is `tx_hold`.
- **Simultaneous events.**
  - Pop and byte completion in the same cycle: the pop applies first. Result: `rx_valid`=1 and no overrun.
  - `tx_hold` write and reload in the same cycle: the written value is used for the reload, and `tx_empty`=1 afterwards.
  - Overrun clear and a new overrun in the same cycle: `overrun`=1.

## Timing
- **Reset** (when `rst_n`=0 at a clk edge):
  - `rx_data`, `shift_rx`, `bitcnt`, `idle_cnt`, `rx_valid`, `overrun` = 0.
  - `tx_empty`=1; `tx_hold`=8'h00; `shift_tx`=`TX_FILL`; `miso`=`TX_FILL[7]`.
  - `miso_oe`=0; `irq`=0; synchronizer flops = 1 for `ss_n` and 0 for the others.
- **Reset mid-frame:** all state above is forced to its reset value. The partial byte is lost and no `rx_valid` is produced.
- **Edge latency:** an `sclk` edge is acted upon `SYNC_STAGES`+1 clk edges after it reaches the pin.
- **`miso` update:** `miso` changes 1 clk after the action. With the default depth that is 4 clk after the falling `sclk`.
- **Half-period requirement:** the `sclk` half-period must be ≥ `SYNC_STAGES`+3 clk cycles. This is 5 at the default depth, i.e. a master `clkdiv` ≥ 4 on the same clock.
- **Receive visibility:** `rx_valid` and `irq` rise 1 clk after the 8th rising `sclk` edge is detected.
- **Register writes:** take effect at the clk edge where `cs&wr` is high.
- **Register reads:** combinational in the same cycle as `cs&rd`.

## Test plan
- **Basic byte exchange:**
  - Stimulus: reset; write 8'h3C to addr 00; `ss_n`=0; master sends 8'hA5 with half-period 8 clk.
  - Required: `miso` bits 0,0,1,1,1,1,0,0; `rx_data`=8'hA5; `rx_valid`=1; `irq`=1; `tx_empty`=1.
- **Fill byte:**
  - Stimulus: no `tx_hold` write; receive 8'h01.
  - Required: `miso` outputs 8'hFF; status read = 8'h03.
- **Overrun:**
  - Stimulus: receive 8'h11, then 8'h22 without a read.
  - Required: `rx_data`=8'h22; status bit2=1. Writing 8'h04 to addr 01 clears it; `irq` stays 1 until addr 00 is read.
- **Pop collides with completion:**
  - Stimulus: read addr 00 in the exact cycle the second byte completes.
  - Required: `overrun`=0; `rx_valid`=1; `rx_data` holds the second byte.
- **Idle abort:**
  - Stimulus: `IDLE_TIMEOUT`=16; send 3 bits, stall 20 clk, then send 8'hC3.
  - Required: addr 10 reads 0 after the stall; `rx_data`=8'hC3.
- **Reset mid-byte:**
  - Stimulus: assert `rst_n`=0 for 1 clk after 5 bits.
  - Required: `bitcnt`=0; `rx_valid`=0; `miso`=1. The next full byte is received correctly.
